// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: hazard-detection inputs from the pipeline plus the stall, flush,
// forwarding and status outputs. The master modport is the datapath side; slave is the controller.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       Rs1E;
   logic [4:0]       Rs2E;
   logic [4:0]       RdE;
   logic             RegWriteE;
   logic [1:0]       ResultSrcE;
   logic             PCSrcE;
   logic [4:0]       RdM;
   logic             RegWriteM;
   logic             MemReqM;
   logic             MemReadyM;
   logic [4:0]       RdW;
   logic             RegWriteW;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             StallM;
   logic             FlushD;
   logic             FlushE;
   logic             FlushW;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
             RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, mem_err, stall_cycles, flush_events
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
             RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, mem_err, stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32 pipeline with a memory-wait watchdog.
// Build macro PIPE_PERF_CNT_EN adds saturating stall-cycle and branch-flush counters.
module hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);
   // state | meaning
   // RUN   | no data-memory access outstanding
   // WAIT  | access issued and not ready; watchdog timer running
   // ERR   | watchdog expired; pipeline frozen until reset
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t           state;
   logic [TMR_W-1:0] wait_tmr;
   logic             mem_err_q;
   logic             ld_stall;
   logic             mem_stall;

   always_comb begin
      ld_stall  = (hz.ResultSrcE == 2'b01) && hz.RegWriteE && (hz.RdE != 5'd0) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
      mem_stall = ((state == RUN) && hz.MemReqM && !hz.MemReadyM) ||
                  ((state == WAIT) && !hz.MemReadyM) ||
                  (state == ERR);
   end

   always_comb begin
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.FlushW    = 1'b0;
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      if (!rst_n) begin
         // D/E registers are held clear for as long as reset is asserted
         hz.FlushD = 1'b1;
         hz.FlushE = 1'b1;
      end else begin
         if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E))
            hz.ForwardAE = 2'b10;
         else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E))
            hz.ForwardAE = 2'b01;
         if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E))
            hz.ForwardBE = 2'b10;
         else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E))
            hz.ForwardBE = 2'b01;

         // a memory stall freezes everything, deferring branches and load-use
         if (mem_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
         end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
         end else if (ld_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
         end
      end
   end

   // watchdog is a down-counter: loaded on entering WAIT, ERR on terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wait_tmr  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (hz.MemReqM && !hz.MemReadyM) begin
                  state    <= WAIT;
                  wait_tmr <= TMR_W'(TIMEOUT - 1);
               end
            end
            WAIT: begin
               if (hz.MemReadyM) begin
                  state    <= RUN;
                  wait_tmr <= '0;
               end else if (wait_tmr == '0) begin
                  state     <= ERR;
                  mem_err_q <= 1'b1;
               end else begin
                  wait_tmr <= wait_tmr - TMR_W'(1);
               end
            end
            ERR: begin
               mem_err_q <= 1'b1;
            end
            default: begin
               state     <= ERR;
               mem_err_q <= 1'b1;
            end
         endcase
      end
   end

   assign hz.mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;
   logic             any_stall;
   logic             br_flush;

   assign any_stall = hz.StallF | hz.StallD | hz.StallE | hz.StallM;
   assign br_flush  = rst_n & ~mem_stall & hz.PCSrcE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (any_stall && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
         if (br_flush && (flush_q != '1))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign hz.stall_cycles = stall_q;
   assign hz.flush_events = flush_q;
`else
   assign hz.stall_cycles = '0;
   assign hz.flush_events = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, hand-written memory-wait/timeout/reset
// sequences, then randomized cycles against a behavioural model of the pipeline rules.
module tb_hazard_ctrl;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 32;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam logic [10:0] RST_VEC   = 11'b0000_110_00_00;
   localparam logic [10:0] STALL_VEC = 11'b1111_001_00_00;
   localparam logic [10:0] BR_VEC    = 11'b0000_110_00_00;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();
   hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .hz(hif));

   int tests_run = 0;
   int fails     = 0;

   typedef struct {
      string       name;
      logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde;
      logic        rwe;
      logic [1:0]  rse;
      logic [4:0]  rdm;
      logic        rwm;
      logic [4:0]  rdw;
      logic        rww, pc, req, rdy;
      logic [10:0] exp;  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB}
   } vec_t;
   vec_t vecs[12];

   // behavioural model: count of consecutive not-ready cycles of an outstanding access
   int              m_consec;
   bit              m_err;
   longint unsigned m_stall_cnt, m_flush_cnt;
   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] obs();
      return {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE,
              hif.FlushW, hif.ForwardAE, hif.ForwardBE};
   endfunction

   task automatic clear_in();
      hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0;
      hif.RegWriteE = 0; hif.ResultSrcE = 0; hif.PCSrcE = 0; hif.RdM = 0;
      hif.RegWriteM = 0; hif.MemReqM = 0; hif.MemReadyM = 0; hif.RdW = 0; hif.RegWriteW = 0;
   endtask

   task automatic drive(input vec_t v);
      hif.Rs1D = v.rs1d; hif.Rs2D = v.rs2d; hif.Rs1E = v.rs1e; hif.Rs2E = v.rs2e;
      hif.RdE = v.rde; hif.RegWriteE = v.rwe; hif.ResultSrcE = v.rse; hif.PCSrcE = v.pc;
      hif.RdM = v.rdm; hif.RegWriteM = v.rwm; hif.MemReqM = v.req; hif.MemReadyM = v.rdy;
      hif.RdW = v.rdw; hif.RegWriteW = v.rww;
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2'b10;
      if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit m_memstall();
      return m_err || (!hif.MemReadyM && (hif.MemReqM || m_consec > 0));
   endfunction

   function automatic logic [10:0] m_expect();
      bit lu;
      logic [3:0] fw;
      if (!rst_n) return RST_VEC;
      lu = (hif.ResultSrcE == 2'b01) && hif.RegWriteE && hif.RdE != 0 &&
           (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
      fw = {m_fwd(hif.Rs1E), m_fwd(hif.Rs2E)};
      if (m_memstall()) return {7'b1111_001, fw};
      if (hif.PCSrcE)   return {7'b0000_110, fw};
      if (lu)           return {7'b1100_010, fw};
      return {7'b0, fw};
   endfunction

   task automatic m_reset();
      m_consec = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
   endtask

   task automatic m_step();
      logic [10:0] e;
      bit ms;
      if (!rst_n) begin
         m_reset();
         return;
      end
      e  = m_expect();
      ms = m_memstall();
      if (|e[10:7] && m_stall_cnt != CNT_MAX) m_stall_cnt++;
      if (!ms && hif.PCSrcE && m_flush_cnt != CNT_MAX) m_flush_cnt++;
      if (!m_err) begin
         if (!hif.MemReadyM && (hif.MemReqM || m_consec > 0)) begin
            m_consec++;
            if (m_consec > TIMEOUT) m_err = 1;
         end else begin
            m_consec = 0;
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{"ld_use_rs2",  1, 5, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 11'b1100_010_00_00};
      vecs[1]  = '{"ld_use_x0",   0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 11'b0};
      vecs[2]  = '{"fwd_a_m",     0, 0, 7, 0, 0, 0, 2'b00, 7, 1, 7, 1, 0, 0, 0, 11'b0000_000_10_00};
      vecs[3]  = '{"fwd_a_w",     0, 0, 7, 0, 0, 0, 2'b00, 7, 0, 7, 1, 0, 0, 0, 11'b0000_000_01_00};
      vecs[4]  = '{"fwd_x0",      0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 11'b0};
      vecs[5]  = '{"br_over_lu",  1, 5, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 11'b0000_110_00_00};
      vecs[6]  = '{"zero_wait",   0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 11'b0};
      vecs[7]  = '{"fwd_split",   0, 0, 3, 4, 0, 0, 2'b00, 4, 1, 3, 1, 0, 0, 0, 11'b0000_000_01_10};
      vecs[8]  = '{"lu_not_load", 6, 0, 0, 0, 6, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 11'b0};
      vecs[9]  = '{"lu_no_wr",    6, 0, 0, 0, 6, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 11'b0};
      vecs[10] = '{"lu_rs1_fwdb", 9, 0, 0, 9, 9, 1, 2'b01, 0, 0, 9, 1, 0, 0, 0, 11'b1100_010_00_01};
      vecs[11] = '{"fwd_b_m_pri", 0, 0, 0, 2, 0, 0, 2'b00, 2, 1, 2, 1, 0, 0, 0, 11'b0000_000_00_10};

      // reset values with active hazard inputs present
      rst_n = 1'b0;
      drive(vecs[10]);
      #2;
      check("rst_outputs", obs(), RST_VEC);
      check("rst_mem_err", hif.mem_err, 0);
      check("rst_stall_cnt", hif.stall_cycles, 0);
      check("rst_flush_cnt", hif.flush_events, 0);
      next_cycle();
      rst_n = 1'b1;
      clear_in();

      foreach (vecs[i]) begin
         next_cycle();
         drive(vecs[i]);
         @(negedge clk);
         check(vecs[i].name, obs(), vecs[i].exp);
      end
      check("table_mem_err", hif.mem_err, 0);

      // wait released on the 3rd cycle with a branch pending throughout
      next_cycle();
      clear_in(); hif.MemReqM = 1; hif.PCSrcE = 1;
      @(negedge clk); check("wait_c1", obs(), STALL_VEC);
      next_cycle();
      @(negedge clk); check("wait_c2", obs(), STALL_VEC);
      next_cycle();
      hif.MemReadyM = 1;
      @(negedge clk); check("release_branch", obs(), BR_VEC);
      next_cycle();
      clear_in();
      @(negedge clk); check("after_release_run", obs(), 0);
      check("after_release_err", hif.mem_err, 0);

      // ready on the last permitted wait cycle returns to RUN
      next_cycle();
      hif.MemReqM = 1;
      for (int k = 0; k < TIMEOUT; k++) begin
         @(negedge clk); check("tmo_edge_stall", obs(), STALL_VEC);
         next_cycle();
      end
      hif.MemReadyM = 1;
      @(negedge clk); check("tmo_edge_ready", obs(), 0);
      next_cycle();
      clear_in();
      @(negedge clk); check("tmo_edge_run", obs(), 0);
      check("tmo_edge_err", hif.mem_err, 0);

      // TIMEOUT+1 not-ready cycles enter ERR
      next_cycle();
      hif.MemReqM = 1;
      for (int k = 0; k <= TIMEOUT; k++) begin
         @(negedge clk); check("tmo_stall", obs(), STALL_VEC);
         check("tmo_err_pending", hif.mem_err, 0);
         next_cycle();
      end
      hif.MemReqM = 0; hif.MemReadyM = 1;
      @(negedge clk); check("err_frozen", obs(), STALL_VEC);
      check("err_set", hif.mem_err, 1);
      #2 rst_n = 1'b0;
      #1;
      check("err_rst_clears", hif.mem_err, 0);
      check("err_rst_outputs", obs(), RST_VEC);
      next_cycle();
      rst_n = 1'b1;
      clear_in();
      @(negedge clk); check("err_rst_run", obs(), 0);

      // async reset while in WAIT
      next_cycle();
      hif.MemReqM = 1;
      next_cycle();
      @(negedge clk); check("midwait_stall", obs(), STALL_VEC);
      #2 rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      clear_in();
      @(negedge clk); check("midwait_rst_run", obs(), 0);

      // counters: two-cycle memory wait then one taken branch
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      next_cycle();
      hif.MemReqM = 1;
      next_cycle();
      next_cycle();
      hif.MemReadyM = 1;
      next_cycle();
      clear_in(); hif.PCSrcE = 1;
      next_cycle();
      clear_in();
      @(negedge clk);
      check("cnt_stall", hif.stall_cycles, PERF ? 2 : 0);
      check("cnt_flush", hif.flush_events, PERF ? 1 : 0);
      rst_n = 1'b0;
      #1;
      check("cnt_rst_stall", hif.stall_cycles, 0);
      check("cnt_rst_flush", hif.flush_events, 0);
      next_cycle();
      rst_n = 1'b1;

      // randomized cycles against the behavioural model
      m_reset();
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         rst_n = ($urandom_range(0, 59) != 0);
         hif.Rs1D = 5'($urandom_range(0, 3)); hif.Rs2D = 5'($urandom_range(0, 3));
         hif.Rs1E = 5'($urandom_range(0, 3)); hif.Rs2E = 5'($urandom_range(0, 3));
         hif.RdE  = 5'($urandom_range(0, 3)); hif.RdM  = 5'($urandom_range(0, 3));
         hif.RdW  = 5'($urandom_range(0, 3));
         hif.RegWriteE  = 1'($urandom_range(0, 1));
         hif.RegWriteM  = 1'($urandom_range(0, 1));
         hif.RegWriteW  = 1'($urandom_range(0, 1));
         hif.ResultSrcE = 2'($urandom_range(0, 3));
         hif.PCSrcE     = ($urandom_range(0, 3) == 0);
         hif.MemReqM    = ($urandom_range(0, 2) == 0);
         hif.MemReadyM  = ($urandom_range(0, 1) == 0);
         @(negedge clk);
         if (!rst_n) m_reset();
         check("rand_outputs", obs(), m_expect());
         check("rand_mem_err", hif.mem_err, m_err);
         check("rand_stall_cnt", hif.stall_cycles, PERF ? m_stall_cnt : 0);
         check("rand_flush_cnt", hif.flush_events, PERF ? m_flush_cnt : 0);
         m_step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
